// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch and execute stages: instruction
// geometry, field positions, opcode constants and the fetch FSM state type.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    // Instruction layout: {src[7:6], dst[5:4], opcode[3:0]}
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;
    localparam int DST_LSB = 4;
    localparam int DST_MSB = 5;
    localparam int SRC_LSB = 6;
    localparam int SRC_MSB = 7;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
    typedef logic [DST_MSB-DST_LSB:0] reg_sel_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_ADD = 4'h1;
    localparam opcode_t OP_SUB = 4'h2;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_READ    = 2'd2,
        ST_PRESENT = 2'd3
    } fetch_state_t;

    // Field extractors used by the execute stage when decoding.
    function automatic opcode_t instr_opcode(input logic [DATA_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic reg_sel_t instr_dst(input logic [DATA_W-1:0] instr);
        return instr[DST_MSB:DST_LSB];
    endfunction

    function automatic reg_sel_t instr_src(input logic [DATA_W-1:0] instr);
        return instr[SRC_MSB:SRC_LSB];
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Fetch -> execute link: instruction handshake, presented PC, and the
// branch redirect coming back from execute.
interface cpu_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_out;

    // Fetch side drives the instruction, execute side accepts and redirects.
    modport master (
        output instr_out,
        output instr_valid,
        output pc_out,
        input  instr_ready,
        input  br_valid,
        input  br_target
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        input  pc_out,
        output instr_ready,
        output br_valid,
        output br_target
    );

endinterface

// File: rtl/fetch_imem.sv
// Program memory: DEPTH x DATA_W, one write port, one synchronous read
// port. Contents are intentionally not reset so it maps onto block RAM.
module fetch_imem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port; read data holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage. Programs are entered byte-by-byte from the DIP
// switches in load mode, then stepped out one instruction at a time to the
// execute stage over a valid/ready handshake with branch redirect support.
// Optional feature macro: FETCH_FREERUN_EN -- when defined, the free_run
// level fetches back-to-back; otherwise free_run is ignored.
module cpu_fetch_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_mode,
    input  logic                        step,
    input  logic                        free_run,
    input  logic [DATA_W-1:0]           prog_din,
    output logic [$clog2(DEPTH):0]      prog_len,
    output logic                        prog_full,
    cpu_fetch_unit_if.master            fe
);

    import cpu_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W:0]    prog_len_reg, prog_len_next;

    logic               mem_wr_en;
    logic               mem_rd_en;
    logic [DATA_W-1:0]  mem_rd_data;

    logic               fetch_run;
    logic               run_go;
    logic               full_w;
    logic               have_prog;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  br_pc;

`ifdef FETCH_FREERUN_EN
    assign fetch_run = free_run & ~load_mode;
`else
    assign fetch_run = 1'b0;
    logic unused_free_run;
    assign unused_free_run = free_run;
`endif

    assign full_w    = (prog_len_reg == (ADDR_W+1)'(DEPTH));
    assign have_prog = (prog_len_reg != '0);
    // Free-running only makes sense with a program to run.
    assign run_go    = fetch_run & have_prog;

    // Sequential successor wraps at the last loaded word, not at DEPTH.
    assign pc_inc = (({1'b0, pc_reg} + (ADDR_W+1)'(1)) == prog_len_reg) ? '0
                                                                        : pc_reg + ADDR_W'(1);

    // Redirects outside the loaded program restart from the beginning.
    assign br_pc = ({1'b0, fe.br_target} < prog_len_reg) ? fe.br_target : '0;

    fetch_imem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (prog_len_reg[ADDR_W-1:0]),
        .wr_data (prog_din),
        .rd_en   (mem_rd_en),
        .rd_addr (pc_reg),
        .rd_data (mem_rd_data)
    );

    // State, program counter and program length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_LOAD;
            pc_reg       <= '0;
            prog_len_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            prog_len_reg <= prog_len_next;
        end
    end

    // Next-state logic: program entry, fetch sequencing, branch and handshake.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        prog_len_next = prog_len_reg;
        mem_wr_en     = 1'b0;
        mem_rd_en     = 1'b0;

        if (state_reg == ST_LOAD) begin
            if (!load_mode) begin
                state_next = ST_IDLE;
                pc_next    = '0;
            end else if (step && !full_w) begin
                mem_wr_en     = 1'b1;
                prog_len_next = prog_len_reg + (ADDR_W+1)'(1);
            end
        end else if (load_mode) begin
            // Re-entering program entry beats any branch or transfer.
            state_next    = ST_LOAD;
            prog_len_next = '0;
            pc_next       = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (fe.br_valid) begin
                        pc_next    = br_pc;
                        state_next = run_go ? ST_READ : ST_IDLE;
                    end else if ((step || fetch_run) && have_prog) begin
                        state_next = ST_READ;
                    end
                end
                ST_READ: begin
                    mem_rd_en = 1'b1;
                    if (fe.br_valid) begin
                        // Squash the read in flight; refetch from the target.
                        pc_next    = br_pc;
                        state_next = run_go ? ST_READ : ST_IDLE;
                    end else begin
                        state_next = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (fe.instr_ready) begin
                        // Transfer completes; a simultaneous branch still steers the PC.
                        pc_next    = fe.br_valid ? br_pc : pc_inc;
                        state_next = run_go ? ST_READ : ST_IDLE;
                    end else if (fe.br_valid) begin
                        pc_next    = br_pc;
                        state_next = run_go ? ST_READ : ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_LOAD;
                end
            endcase
        end
    end

    // The RAM read register holds the presented word; outside PRESENT the
    // bus reads zero so reset and squash never expose stale or unknown data.
    assign fe.instr_valid = (state_reg == ST_PRESENT);
    assign fe.instr_out   = (state_reg == ST_PRESENT) ? mem_rd_data : '0;
    assign fe.pc_out      = pc_reg;
    assign prog_len       = prog_len_reg;
    assign prog_full      = full_w;

endmodule
